// File: rtl/clock_alarm_ctrl_pkg.sv
// Shared types and constants for the alarm controller: state encoding,
// time-of-day field widths and range limits, and an alarm-time range check.
package clock_alarm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } alm_state_t;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
  } hhmm_t;

  // True when an hh:mm pair names a real time of day.
  function automatic logic hhmm_valid(input hhmm_t t);
    return (t.hour <= HOUR_MAX) && (t.minute <= MIN_MAX);
  endfunction

endpackage

// File: rtl/clock_alarm_ctrl_if.sv
// Alarm-time programming port: valid/ready write of hh:mm, error pulse for
// out-of-range writes, and read-back of the stored alarm time.
interface clock_alarm_ctrl_if;
  import clock_alarm_ctrl_pkg::*;

  logic              set_valid;
  logic [HOUR_W-1:0] set_hour;
  logic [MIN_W-1:0]  set_min;
  logic              set_ready;
  logic              set_err;
  logic [HOUR_W-1:0] alm_hour;
  logic [MIN_W-1:0]  alm_min;

  modport master (
    output set_valid, set_hour, set_min,
    input  set_ready, set_err, alm_hour, alm_min
  );

  modport slave (
    input  set_valid, set_hour, set_min,
    output set_ready, set_err, alm_hour, alm_min
  );

endinterface

// File: rtl/clock_alarm_ctrl_tick_edge.sv
// One-cycle rising-edge detector for a clk-synchronous divided-clock level.
module clock_alarm_ctrl_tick_edge (
  input  logic clk,
  input  logic x_clr,
  input  logic sig_in,
  output logic tick
);

  logic sig_d;
  logic sig_q;

  // Previous-cycle copy of the level.
  always_comb begin
    sig_d = sig_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; reset is high so a level already high after reset does
  // not produce a spurious tick.
  // Delay register for edge detection.
  always_ff @(posedge clk or negedge x_clr) begin
    if (!x_clr) sig_q <= 1'b1;
    else        sig_q <= sig_d;
  end

  assign tick = sig_in & ~sig_q;

endmodule

// File: rtl/clock_alarm_ctrl.sv
// Alarm controller: holds a programmable hh:mm alarm, detects the daily match
// against the running clock, and sequences ringing, snooze and auto-stop while
// driving a beeping buzzer and UI status.
module clock_alarm_ctrl
  import clock_alarm_ctrl_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3,
  parameter int BEEP_MS     = 500
) (
  input  logic              clk,
  input  logic              x_clr,
  input  logic              D_1ms_clk,
  input  logic              D_1s_clk,
  input  logic [HOUR_W-1:0] clk_1h_count,
  input  logic [MIN_W-1:0]  clk_1m_count,
  input  logic [SEC_W-1:0]  clk_1s_count,
  input  logic              alarm_en,
  input  logic              snooze_req,
  input  logic              stop_req,
  clock_alarm_ctrl_if.slave set_if,
  output logic              alarm_ring,
  output logic              buzz,
  output logic [1:0]        alm_state
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
  localparam int SNC_W  = $clog2(MAX_SNOOZE + 2);
  localparam int MS_W   = $clog2(BEEP_MS + 1);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
  localparam logic [RING_W-1:0] RING_ONE  = RING_W'(1);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);
  localparam logic [SNC_W-1:0]  SNC_MAX   = SNC_W'(MAX_SNOOZE);
  localparam logic [SNC_W-1:0]  SNC_ONE   = SNC_W'(1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(BEEP_MS - 1);
  localparam logic [MS_W-1:0]   MS_ONE    = MS_W'(1);

  logic sec_tick;
  logic ms_tick;

  clock_alarm_ctrl_tick_edge u_sec_edge (
    .clk    (clk),
    .x_clr  (x_clr),
    .sig_in (D_1s_clk),
    .tick   (sec_tick)
  );

  clock_alarm_ctrl_tick_edge u_ms_edge (
    .clk    (clk),
    .x_clr  (x_clr),
    .sig_in (D_1ms_clk),
    .tick   (ms_tick)
  );

  alm_state_t        state_q, state_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic [SNC_W-1:0]  snooze_cnt_q, snooze_cnt_d;
  logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
  logic              buzz_q, buzz_d;
  logic              alarm_ring_q, alarm_ring_d;
  logic              set_err_q, set_err_d;
  hhmm_t             alm_q, alm_d;
  logic              match_q, match_d;

  logic  set_ready;
  logic  match;
  logic  match_rise;
  logic  ring_start;
  hhmm_t wr_time;

  assign set_ready  = (state_q == ST_IDLE) || (state_q == ST_ARMED);
  assign wr_time    = '{hour: set_if.set_hour, minute: set_if.set_min};
  assign match      = (clk_1h_count == alm_q.hour) && (clk_1m_count == alm_q.minute) &&
                      (clk_1s_count == '0);
  assign match_rise = match & ~match_q;

  // Next-state logic: alarm-time writes, FSM sequencing and beep pattern.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    ms_cnt_d     = ms_cnt_q;
    buzz_d       = buzz_q;
    alm_d        = alm_q;
    set_err_d    = 1'b0;
    match_d      = match;
    ring_start   = 1'b0;

    if (set_if.set_valid && set_ready) begin
      if (hhmm_valid(wr_time)) alm_d     = wr_time;
      else                     set_err_d = 1'b1;
    end

    if (!alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;
        ST_ARMED: begin
          if (match_rise) begin
            state_d      = ST_RINGING;
            ring_cnt_d   = RING_LOAD;
            snooze_cnt_d = '0;
            ring_start   = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop_req) begin
            state_d = ST_ARMED;
          end else if (snooze_req) begin
            // Out of snoozes: a further request ends this alarm event.
            if (snooze_cnt_q == SNC_MAX) begin
              state_d = ST_ARMED;
            end else begin
              state_d      = ST_SNOOZE;
              snz_cnt_d    = SNZ_LOAD;
              snooze_cnt_d = snooze_cnt_q + SNC_ONE;
            end
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_ONE) state_d    = ST_ARMED;
            else                        ring_cnt_d = ring_cnt_q - RING_ONE;
          end
        end
        ST_SNOOZE: begin
          if (stop_req) begin
            state_d = ST_ARMED;
          end else if (sec_tick) begin
            if (snz_cnt_q == SNZ_ONE) begin
              state_d    = ST_RINGING;
              ring_cnt_d = RING_LOAD;
              ring_start = 1'b1;
            end else begin
              snz_cnt_d = snz_cnt_q - SNZ_ONE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Beep starts on at every ring entry and flips every BEEP_MS ms ticks.
    if (state_d != ST_RINGING) begin
      buzz_d   = 1'b0;
      ms_cnt_d = '0;
    end else if (ring_start) begin
      buzz_d   = 1'b1;
      ms_cnt_d = '0;
    end else if (ms_tick) begin
      if (ms_cnt_q == MS_LAST) begin
        buzz_d   = ~buzz_q;
        ms_cnt_d = '0;
      end else begin
        ms_cnt_d = ms_cnt_q + MS_ONE;
      end
    end

    alarm_ring_d = (state_d == ST_RINGING);
  end

  // State and registered outputs; reset clears any pending alarm activity.
  always_ff @(posedge clk or negedge x_clr) begin
    if (!x_clr) begin
      state_q      <= ST_IDLE;
      ring_cnt_q   <= '0;
      snz_cnt_q    <= '0;
      snooze_cnt_q <= '0;
      ms_cnt_q     <= '0;
      buzz_q       <= 1'b0;
      alarm_ring_q <= 1'b0;
      set_err_q    <= 1'b0;
      alm_q        <= '0;
      match_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      ms_cnt_q     <= ms_cnt_d;
      buzz_q       <= buzz_d;
      alarm_ring_q <= alarm_ring_d;
      set_err_q    <= set_err_d;
      alm_q        <= alm_d;
      match_q      <= match_d;
    end
  end

  assign alarm_ring       = alarm_ring_q;
  assign buzz             = buzz_q;
  assign alm_state        = state_q;
  assign set_if.set_ready = set_ready;
  assign set_if.set_err   = set_err_q;
  assign set_if.alm_hour  = alm_q.hour;
  assign set_if.alm_min   = alm_q.minute;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Self-checking bench for clock_alarm_ctrl with a behavioural model driven by
// elapsed-seconds / elapsed-ms bookkeeping and randomized clock and request stimulus.
module tb_clock_alarm_ctrl;
  import clock_alarm_ctrl_pkg::*;

  localparam int RING = 5;
  localparam int SNZ  = 3;
  localparam int MAXS = 2;
  localparam int BEEP = 4;
  localparam int DAY  = 86400;

  logic        clk = 1'b0;
  logic        x_clr = 1'b0;
  logic        D_1ms_clk = 1'b0;
  logic        D_1s_clk = 1'b0;
  logic [4:0]  clk_1h_count = '0;
  logic [5:0]  clk_1m_count = '0;
  logic [5:0]  clk_1s_count = '0;
  logic        alarm_en = 1'b0;
  logic        snooze_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        alarm_ring;
  logic        buzz;
  logic [1:0]  alm_state;

  clock_alarm_ctrl_if sif ();

  clock_alarm_ctrl #(
    .RING_SECS  (RING),
    .SNOOZE_SECS(SNZ),
    .MAX_SNOOZE (MAXS),
    .BEEP_MS    (BEEP)
  ) dut (
    .clk         (clk),
    .x_clr       (x_clr),
    .D_1ms_clk   (D_1ms_clk),
    .D_1s_clk    (D_1s_clk),
    .clk_1h_count(clk_1h_count),
    .clk_1m_count(clk_1m_count),
    .clk_1s_count(clk_1s_count),
    .alarm_en    (alarm_en),
    .snooze_req  (snooze_req),
    .stop_req    (stop_req),
    .set_if      (sif),
    .alarm_ring  (alarm_ring),
    .buzz        (buzz),
    .alm_state   (alm_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int tod    = 0;

  // Reference model: state as 0..3, time spent in the current phase.
  int m_state, m_ring_secs, m_snz_secs, m_snoozes, m_ms_ticks, m_ah, m_am;
  bit m_err, m_s_prev, m_ms_prev, m_match_prev;

  function automatic void model_reset();
    m_state = 0; m_ring_secs = 0; m_snz_secs = 0; m_snoozes = 0; m_ms_ticks = 0;
    m_ah = 0; m_am = 0; m_err = 0;
    m_s_prev = 1; m_ms_prev = 1; m_match_prev = 1;
  endfunction

  function automatic void model_step();
    bit st, mt, match, rise;
    if (!x_clr) begin
      model_reset();
      return;
    end
    st    = D_1s_clk && !m_s_prev;
    mt    = D_1ms_clk && !m_ms_prev;
    match = (tod / 3600 == m_ah) && ((tod / 60) % 60 == m_am) && (tod % 60 == 0);
    rise  = match && !m_match_prev;
    m_s_prev = D_1s_clk; m_ms_prev = D_1ms_clk; m_match_prev = match;
    m_err = 0;
    if (sif.set_valid && m_state <= 1) begin
      if (int'(sif.set_hour) <= 23 && int'(sif.set_min) <= 59) begin
        m_ah = int'(sif.set_hour); m_am = int'(sif.set_min);
      end else m_err = 1;
    end
    if (!alarm_en) m_state = 0;
    else case (m_state)
      0: m_state = 1;
      1: if (rise) begin
           m_state = 2; m_snoozes = 0; m_ring_secs = 0; m_ms_ticks = 0;
         end
      2: if (stop_req) m_state = 1;
         else if (snooze_req) begin
           if (m_snoozes >= MAXS) m_state = 1;
           else begin m_snoozes++; m_state = 3; m_snz_secs = 0; end
         end else begin
           if (st) begin
             m_ring_secs++;
             if (m_ring_secs == RING) m_state = 1;
           end
           if (m_state == 2 && mt) m_ms_ticks++;
         end
      default: if (stop_req) m_state = 1;
         else if (st) begin
           m_snz_secs++;
           if (m_snz_secs == SNZ) begin m_state = 2; m_ring_secs = 0; m_ms_ticks = 0; end
         end
    endcase
  endfunction

  function automatic logic [16:0] mdl_vec();
    logic [1:0] s;
    logic [4:0] h;
    logic [5:0] m;
    logic       bz;
    s  = 2'(m_state);
    h  = 5'(m_ah);
    m  = 6'(m_am);
    bz = (m_state == 2) && ((m_ms_ticks / BEEP) % 2 == 0);
    return {s, m_state == 2, bz, m_state <= 1, m_err, h, m};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {alm_state, alarm_ring, buzz, sif.set_ready, sif.set_err, sif.alm_hour, sif.alm_min};
  endfunction

  // Advance one clock, update the model, compare every output.
  task automatic cyc(input string tag);
    logic [16:0] got, exp;
    @(posedge clk);
    model_step();
    #1;
    got = dut_vec();
    exp = mdl_vec();
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t {state,ring,buzz,rdy,err,ah,am} got=%h exp=%h", tag, $time, got, exp);
    end
    D_1ms_clk = 1'($urandom_range(0, 1));
  endtask

  task automatic set_tod(input int t);
    tod = ((t % DAY) + DAY) % DAY;
    clk_1h_count = 5'(tod / 3600);
    clk_1m_count = 6'((tod / 60) % 60);
    clk_1s_count = 6'(tod % 60);
  endtask

  // One wall-clock second of randomized length, counts step with D_1s_clk rise.
  task automatic sec_step(input string tag);
    int len;
    len = $urandom_range(8, 16);
    set_tod(tod + 1);
    D_1s_clk = 1'b1;
    for (int i = 0; i < len; i++) begin
      if (i == 3) D_1s_clk = 1'b0;
      cyc(tag);
    end
  endtask

  task automatic write_alarm(input int h, input int m, input string tag);
    sif.set_valid = 1'b1;
    sif.set_hour  = 5'(h);
    sif.set_min   = 6'(m);
    cyc(tag);
    sif.set_valid = 1'b0;
  endtask

  // Jump to one second before hh:mm:00 and step into the alarm minute.
  task automatic ring_now(input int h, input int m, input string tag);
    set_tod(h * 3600 + m * 60 - 1);
    cyc(tag);
    sec_step(tag);
    n_chk++;
    if (alm_state !== 2'd2) begin
      n_fail++;
      $display("FAIL %s_ring got state=%0d exp=2", tag, alm_state);
    end
  endtask

  task automatic test_reset();
    x_clr = 1'b0;
    repeat (3) cyc("reset_hold");
    n_chk++;
    if ({alm_state, alarm_ring, buzz, sif.set_err, sif.alm_hour, sif.alm_min} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got state=%0d ring=%b buzz=%b err=%b alm=%0d:%0d exp all 0",
               alm_state, alarm_ring, buzz, sif.set_err, sif.alm_hour, sif.alm_min);
    end
    x_clr = 1'b1;
    repeat (2) cyc("reset_release");
  endtask

  task automatic test_ring();
    int n;
    write_alarm(7, 30, "ring_write");
    cyc("ring_write");
    n_chk++;
    if (sif.alm_hour !== 5'd7 || sif.alm_min !== 6'd30) begin
      n_fail++;
      $display("FAIL ring_readback got %0d:%0d exp 7:30", sif.alm_hour, sif.alm_min);
    end
    set_tod(7 * 3600 + 29 * 60 + 57);
    alarm_en = 1'b1;
    repeat (2) cyc("ring_arm");
    n_chk++;
    if (alm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ring_armed got state=%0d exp=1", alm_state);
    end
    repeat (2) sec_step("ring_pre");
    set_tod(tod + 1);
    D_1s_clk = 1'b1;
    cyc("ring_entry");
    n_chk++;
    if (alarm_ring !== 1'b1 || buzz !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_entry got ring=%b buzz=%b exp 1 1", alarm_ring, buzz);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 2) D_1s_clk = 1'b0;
      cyc("ring_run");
    end
    n = 0;
    while (alm_state == 2'd2 && n < 20) begin
      sec_step("ring_run");
      n++;
    end
    n_chk++;
    if (n != RING || alm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ring_autostop got secs=%0d state=%0d exp secs=%0d state=1", n, alm_state, RING);
    end
  endtask

  task automatic test_set_err();
    write_alarm(24, 10, "err_hour");
    n_chk++;
    if (sif.set_err !== 1'b1 || sif.alm_hour !== 5'd7 || sif.alm_min !== 6'd30) begin
      n_fail++;
      $display("FAIL err_hour got err=%b alm=%0d:%0d exp 1 7:30", sif.set_err, sif.alm_hour, sif.alm_min);
    end
    cyc("err_hour_clear");
    write_alarm(10, 60, "err_min");
    n_chk++;
    if (sif.set_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_min got err=%b exp 1", sif.set_err);
    end
    cyc("err_min_clear");
    n_chk++;
    if (sif.set_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pulse_width got err=%b exp 0", sif.set_err);
    end
    ring_now(7, 30, "err_oldtime");
    stop_req = 1'b1;
    cyc("err_stop");
    stop_req = 1'b0;
    n_chk++;
    if (alm_state !== 2'd1 || alarm_ring !== 1'b0) begin
      n_fail++;
      $display("FAIL err_stop got state=%0d ring=%b exp 1 0", alm_state, alarm_ring);
    end
  endtask

  task automatic test_snooze();
    int n;
    ring_now(7, 30, "snz");
    for (int k = 0; k < MAXS; k++) begin
      snooze_req = 1'b1;
      cyc("snz_req");
      snooze_req = 1'b0;
      n_chk++;
      if (alm_state !== 2'd3 || buzz !== 1'b0) begin
        n_fail++;
        $display("FAIL snz_enter%0d got state=%0d buzz=%b exp 3 0", k, alm_state, buzz);
      end
      n = 0;
      while (alm_state == 2'd3 && n < 10) begin
        sec_step("snz_wait");
        n++;
      end
      n_chk++;
      if (n != SNZ || alm_state !== 2'd2) begin
        n_fail++;
        $display("FAIL snz_length%0d got secs=%0d state=%0d exp secs=%0d state=2", k, n, alm_state, SNZ);
      end
    end
    snooze_req = 1'b1;
    cyc("snz_over");
    snooze_req = 1'b0;
    n_chk++;
    if (alm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL snz_limit got state=%0d exp 1", alm_state);
    end
  endtask

  task automatic test_stop_beats_snooze();
    ring_now(7, 30, "both");
    snooze_req = 1'b1;
    stop_req   = 1'b1;
    cyc("both_req");
    snooze_req = 1'b0;
    stop_req   = 1'b0;
    n_chk++;
    if (alm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL both_req got state=%0d exp 1", alm_state);
    end
    repeat (2) sec_step("both_after");
  endtask

  task automatic test_disable();
    ring_now(7, 30, "dis");
    snooze_req = 1'b1;
    cyc("dis_snz");
    snooze_req = 1'b0;
    alarm_en = 1'b0;
    cyc("dis_off");
    n_chk++;
    if (alm_state !== 2'd0 || buzz !== 1'b0 || alarm_ring !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_off got state=%0d buzz=%b ring=%b exp 0 0 0", alm_state, buzz, alarm_ring);
    end
    set_tod(7 * 3600 + 30 * 60);
    repeat (3) cyc("dis_hold");
    alarm_en = 1'b1;
    repeat (20) cyc("dis_reen");
    n_chk++;
    if (alm_state !== 2'd1 || alarm_ring !== 1'b0) begin
      n_fail++;
      $display("FAIL dis_no_retro got state=%0d ring=%b exp 1 0", alm_state, alarm_ring);
    end
    repeat (2) sec_step("dis_after");
  endtask

  task automatic test_async_reset();
    ring_now(7, 30, "arst");
    #3;
    x_clr = 1'b0;
    #1;
    n_chk++;
    if ({alm_state, alarm_ring, buzz, sif.set_err, sif.alm_hour, sif.alm_min} !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate got state=%0d ring=%b buzz=%b alm=%0d:%0d exp all 0",
               alm_state, alarm_ring, buzz, sif.alm_hour, sif.alm_min);
    end
    model_reset();
    repeat (2) cyc("arst_hold");
    x_clr = 1'b1;
    repeat (4) cyc("arst_release");
  endtask

  task automatic test_random();
    int ah, am, len;
    for (int r = 0; r < 4; r++) begin
      ah = $urandom_range(0, 23);
      am = $urandom_range(0, 59);
      write_alarm(ah, am, "rnd_write");
      set_tod(ah * 3600 + am * 60 - 3);
      cyc("rnd_jump");
      for (int s = 0; s < 25; s++) begin
        len = $urandom_range(6, 14);
        set_tod(tod + 1);
        D_1s_clk = 1'b1;
        for (int i = 0; i < len; i++) begin
          if (i == 2) D_1s_clk = 1'b0;
          snooze_req    = ($urandom_range(0, 39) == 0);
          stop_req      = ($urandom_range(0, 79) == 0);
          alarm_en      = ($urandom_range(0, 199) != 0);
          sif.set_valid = ($urandom_range(0, 59) == 0);
          sif.set_hour  = 5'($urandom_range(0, 31));
          sif.set_min   = 6'($urandom_range(0, 63));
          cyc("rnd");
        end
      end
      snooze_req = 1'b0;
      stop_req = 1'b0;
      sif.set_valid = 1'b0;
      alarm_en = 1'b1;
      cyc("rnd_idle");
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    sif.set_valid = 1'b0;
    sif.set_hour  = '0;
    sif.set_min   = '0;
    model_reset();
    test_reset();
    test_ring();
    test_set_err();
    test_snooze();
    test_stop_beats_snooze();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
